// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, full-matrix debounce, and a
// single-cycle one-hot event per press (no auto-repeat).
module keypad_scanner #(
  parameter int SCAN_DIV       = 64,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_row,
  output logic [2:0]  key_col,
  output logic [11:0] key_data,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, HELD} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  dwell_reg;
  logic [11:0]    snap_reg, last_snap_reg;
  logic [MW-1:0]  match_reg, match_next;
  logic [11:0]    snap_now;
  logic [3:0]     code_now;
  logic           last_dwell, snap_done, stable, one_hot, emit;

  assign last_dwell = (dwell_reg == DWELL_LAST);
  assign snap_done  = last_dwell && key_col[2];

  // Snapshot including this cycle's row sample; on column 2's last dwell
  // cycle this is the completed full-matrix snapshot.
  always_comb begin
    snap_now = snap_reg;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (last_dwell && key_col[c]) snap_now[3*r+c] = key_row[r];
      end
    end
  end

  always_comb begin
    code_now = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (snap_now[i]) code_now = 4'(i);
    end
  end

  always_comb begin
    if (snap_now == last_snap_reg)
      match_next = (match_reg == MATCH_MAX) ? MATCH_MAX : match_reg + MW'(1);
    else
      match_next = MW'(1);
  end

  assign stable  = snap_done && (match_next == MATCH_MAX);
  assign one_hot = (snap_now != 12'd0) && ((snap_now & (snap_now - 12'd1)) == 12'd0);

  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    if (stable) begin
      case (state_reg)
        IDLE: begin
          if (snap_now != 12'd0) begin
            state_next = HELD;
            emit       = one_hot;  // multi-key snapshots lock out silently
          end
        end
        HELD: begin
          if (snap_now == 12'd0) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      dwell_reg     <= '0;
      key_col       <= 3'b001;
      snap_reg      <= 12'd0;
      last_snap_reg <= 12'd0;
      match_reg     <= '0;
      key_data      <= 12'd0;
      key_valid     <= 1'b0;
      key_code      <= 4'd0;
    end else begin
      state_reg <= state_next;
      snap_reg  <= snap_now;
      if (last_dwell) begin
        dwell_reg <= '0;
        key_col   <= {key_col[1:0], key_col[2]};
      end else begin
        dwell_reg <= dwell_reg + CW'(1);
      end
      if (snap_done) begin
        last_snap_reg <= snap_now;
        match_reg     <= match_next;
      end
      key_valid <= emit;
      key_data  <= emit ? snap_now : 12'd0;
      if (emit) key_code <= code_now;
    end
  end

endmodule
